uart_receiver: RTL

- Serial-to-parallel UART receive stage; the counterpart of the transmitter on the far end of the serial line.
- Consumes the `rx` line (idle-high, 8N1, LSB first) and reconstructs each data word using 16x oversampling.
- Presents each word with a one-cycle `valid` strobe to downstream logic.
- Flags stop-bit (framing) errors and rejects glitch start bits.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_receiver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the receiver and the transmitter.
//   uart_state_t : frame-level FSM states
//   DEF_*        : default clock / line-rate / oversampling constants
//   calc_div     : system clocks per oversampling tick, integer-truncated
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_t;

    localparam int DEF_CLK_FREQ   = 100_000_000;
    localparam int DEF_BAUD       = 57_600;
    localparam int DEF_OVERSAMPLE = 16;

    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divisor counter producing one oversampling tick every DIV clocks.
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-low
//   os_tick : one-cycle pulse when the counter reaches DIV-1
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = calc_div(DEF_CLK_FREQ, DEF_BAUD, DEF_OVERSAMPLE)
) (
    input  logic clk,
    input  logic reset,
    output logic os_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign os_tick = (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: idle-high serial line, 8N1 (or 8E1), LSB first, 16x oversampling.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit and parity_err.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low; clears all state
//   rx         : serial line, asynchronous to clk, idle = 1
//   data       : last good received word
//   valid      : one-cycle pulse when data updates
//   frame_err  : one-cycle pulse when the stop bit samples 0
//   parity_err : (UART_RX_PARITY_EN only) pulses with valid on a parity mismatch
//   busy       : high from start-bit detect until return to IDLE
//   bit_count  : data bits sampled so far in the current frame
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frame_err,
`ifdef UART_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy,
    output logic [3:0]       bit_count
);

    localparam int            DIV       = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(WIDTH - 1);

    logic             rx_p0, rx_p1, rx_s;
    logic             os_tick;
    logic             armed;
    uart_state_t      state, state_nxt;
    logic [TW-1:0]    tick_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             mid_pt, sample_pt, start_det;
    logic             cnt_clr, shift_en, load_word, flag_ferr;
`ifdef UART_RX_PARITY_EN
    logic             par_en, par_bit;
`endif

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .os_tick (os_tick)
    );

    // ---- stage p0/p1: two-flop synchroniser, idles high ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s = rx_p1;

    // A line already low at reset release must not look like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 1'b0;
        end else if (os_tick && rx_s) begin
            armed <= 1'b1;
        end
    end

    assign mid_pt    = os_tick && (tick_cnt == MID_TICK);
    assign sample_pt = os_tick && (tick_cnt == LAST_TICK);
    assign start_det = (state == IDLE) && armed && os_tick && !rx_s;

    // ---- frame FSM: state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- frame FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start_det) state_nxt = START;
            START:  if (mid_pt) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (sample_pt && (bit_count == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (sample_pt) state_nxt = STOP;
`endif
            STOP:   if (sample_pt) state_nxt = rx_s ? IDLE : BREAK;
            BREAK:  if (os_tick && rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- frame FSM: outputs / datapath controls ----
    always_comb begin
        busy      = (state != IDLE);
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        load_word = 1'b0;
        flag_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en    = 1'b0;
`endif
        case (state)
            IDLE, BREAK: cnt_clr = 1'b1;
            // Tick count restarts at mid start bit so later samples land on bit centres.
            START: cnt_clr = mid_pt;
            DATA: begin
                cnt_clr  = sample_pt;
                shift_en = sample_pt;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                cnt_clr = sample_pt;
                par_en  = sample_pt;
            end
`endif
            STOP: begin
                cnt_clr   = sample_pt;
                load_word = sample_pt && rx_s;
                flag_ferr = sample_pt && !rx_s;
            end
            default: ;
        endcase
    end

    // ---- datapath registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt  <= '0;
            bit_count <= '0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= load_word;
            frame_err <= flag_ferr;

            if (cnt_clr) begin
                tick_cnt <= '0;
            end else if (os_tick) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (start_det) begin
                bit_count <= '0;
            end else if (shift_en) begin
                bit_count <= bit_count + 1'b1;
            end

            // LSB arrives first, so shift in from the top.
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[WIDTH-1:1]};
            end

            if (load_word) begin
                data <= shift_reg;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: XOR over data bits and the parity bit must be 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_en) begin
                par_bit <= rx_s;
            end
            parity_err <= load_word && ((^shift_reg) ^ par_bit);
        end
    end
`endif

endmodule
